// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, LSB and memory-controller handshakes around mem_arbiter.
// master is the arbiter's view; slave is the requesters' and controller's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1
);
  localparam int BLOCK_BITS = 32 * (1 << BLOCK_WIDTH);
  // Wide enough to carry the IF block byte count (8 bytes needs 4 bits)
  localparam int MCW_W = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH + 3 : 3;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [BLOCK_BITS-1:0] if_block;

  logic                  lsb_req;
  logic                  lsb_wr;
  logic [2:0]            lsb_width;
  logic [ADDR_WIDTH-1:0] lsb_addr;
  logic [31:0]           lsb_wdata;
  logic                  lsb_rdone;
  logic                  lsb_wdone;
  logic [31:0]           lsb_rdata;

  logic                  mc_en;
  logic                  mc_ifetch;
  logic                  mc_wr;
  logic [MCW_W-1:0]      mc_width;
  logic [ADDR_WIDTH-1:0] mc_addr;
  logic [31:0]           mc_wdata;
  logic                  mc_done;
  logic [BLOCK_BITS-1:0] mc_rdata;

  modport master (
    input  if_req, if_addr, lsb_req, lsb_wr, lsb_width, lsb_addr, lsb_wdata,
           mc_done, mc_rdata,
    output if_done, if_block, lsb_rdone, lsb_wdone, lsb_rdata,
           mc_en, mc_ifetch, mc_wr, mc_width, mc_addr, mc_wdata
  );

  modport slave (
    output if_req, if_addr, lsb_req, lsb_wr, lsb_width, lsb_addr, lsb_wdata,
           mc_done, mc_rdata,
    input  if_done, if_block, lsb_rdone, lsb_wdone, lsb_rdata,
           mc_en, mc_ifetch, mc_wr, mc_width, mc_addr, mc_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-serial memory controller between
// instruction fetch and the load/store buffer, with UART store stalling.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    BLOCK_WIDTH = 1,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR0    = 'h30000,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR1    = 'h30004
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          io_buffer_full,
  input  logic          clear_in,
  mem_arbiter_if.master bus
);
  localparam int               MCW_W    = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH + 3 : 3;
  localparam logic [MCW_W-1:0] IF_WIDTH = MCW_W'(4 * (1 << BLOCK_WIDTH));

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t state, state_nx;
  logic   last_if;
  logic   drop;
  logic   lsb_elig;
  logic   grant_if;
  logic   grant_lsb;
  logic   complete;
  logic   is_store;
  logic   drop_now;

  assign is_store = bus.mc_wr && !bus.mc_ifetch;
  // A flush arriving together with mc_done must still suppress the result
  assign drop_now = drop || (clear_in && !is_store);

  always_comb begin
    state_nx  = state;
    grant_if  = 1'b0;
    grant_lsb = 1'b0;
    complete  = 1'b0;
    lsb_elig  = bus.lsb_req &&
                !(bus.lsb_wr && io_buffer_full &&
                  (bus.lsb_addr == IO_ADDR0 || bus.lsb_addr == IO_ADDR1));
    case (state)
      IDLE: begin
        if (bus.if_req && lsb_elig) begin
          grant_if  = !last_if;
          grant_lsb = last_if;
        end else begin
          grant_if  = bus.if_req;
          grant_lsb = lsb_elig;
        end
        if (grant_if || grant_lsb) state_nx = BUSY;
      end
      BUSY: begin
        if (bus.mc_done) begin
          complete = 1'b1;
          state_nx = GAP;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= IDLE;
    else if (rdy_in) state <= state_nx;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_if       <= 1'b0;
      drop          <= 1'b0;
      bus.mc_en     <= 1'b0;
      bus.mc_ifetch <= 1'b0;
      bus.mc_wr     <= 1'b0;
      bus.mc_width  <= '0;
      bus.mc_addr   <= '0;
      bus.mc_wdata  <= '0;
      bus.if_done   <= 1'b0;
      bus.if_block  <= '0;
      bus.lsb_rdone <= 1'b0;
      bus.lsb_wdone <= 1'b0;
      bus.lsb_rdata <= '0;
    end else if (rdy_in) begin
      bus.if_done   <= 1'b0;
      bus.lsb_rdone <= 1'b0;
      bus.lsb_wdone <= 1'b0;
      if (grant_if) begin
        bus.mc_en     <= 1'b1;
        bus.mc_ifetch <= 1'b1;
        bus.mc_wr     <= 1'b0;
        bus.mc_width  <= IF_WIDTH;
        bus.mc_addr   <= bus.if_addr;
        bus.mc_wdata  <= '0;
        last_if       <= 1'b1;
      end else if (grant_lsb) begin
        bus.mc_en     <= 1'b1;
        bus.mc_ifetch <= 1'b0;
        bus.mc_wr     <= bus.lsb_wr;
        bus.mc_width  <= MCW_W'(bus.lsb_width);
        bus.mc_addr   <= bus.lsb_addr;
        bus.mc_wdata  <= bus.lsb_wdata;
        last_if       <= 1'b0;
      end
      if (state == BUSY && clear_in && !is_store) drop <= 1'b1;
      if (complete) begin
        bus.mc_en <= 1'b0;
        if (!drop_now) begin
          if (bus.mc_ifetch) begin
            bus.if_done  <= 1'b1;
            bus.if_block <= bus.mc_rdata;
          end else if (bus.mc_wr) begin
            bus.lsb_wdone <= 1'b1;
          end else begin
            bus.lsb_rdone <= 1'b1;
            bus.lsb_rdata <= bus.mc_rdata[31:0];
          end
        end
      end
      if (state == GAP) drop <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: acts as requesters and memory controller, with a
// scoreboard of expected downstream requests and completion pulses.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst, rdy, io_full, clr;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic        ifetch;
    logic        wr;
    logic [3:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [2:0]  kind;   // {if_done, lsb_rdone, lsb_wdone}
    logic [63:0] data;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  mem_arbiter_if #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) bus();

  mem_arbiter #(
    .ADDR_WIDTH(32), .BLOCK_WIDTH(1), .IO_ADDR0(32'h30000), .IO_ADDR1(32'h30004)
  ) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .io_buffer_full(io_full),
    .clear_in(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1);
  end

  // Scoreboard monitor: request starts and completion pulses
  logic        en_prev = 1'b0;
  logic [31:0] addr_prev, wdata_prev;
  logic [3:0]  width_prev;
  logic        wr_prev, ifetch_prev;
  req_t        mr;
  done_t       md;
  logic [2:0]  mk;

  always @(posedge clk) begin
    #1;
    if (bus.mc_en === 1'b1 && en_prev !== 1'b1) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got addr=%h ifetch=%b, required no request", bus.mc_addr, bus.mc_ifetch);
      end else begin
        mr = req_q.pop_front();
        if (bus.mc_ifetch !== mr.ifetch || bus.mc_wr !== mr.wr || bus.mc_width !== mr.width ||
            bus.mc_addr !== mr.addr || (mr.wr && bus.mc_wdata !== mr.wdata)) begin
          errors++;
          $display("FAIL req_fields: got if=%b wr=%b w=%0d a=%h d=%h, required if=%b wr=%b w=%0d a=%h d=%h",
                   bus.mc_ifetch, bus.mc_wr, bus.mc_width, bus.mc_addr, bus.mc_wdata,
                   mr.ifetch, mr.wr, mr.width, mr.addr, mr.wdata);
        end
      end
    end
    if (bus.mc_en === 1'b1 && en_prev === 1'b1) begin
      checks++;
      if (bus.mc_addr !== addr_prev || bus.mc_wdata !== wdata_prev || bus.mc_width !== width_prev ||
          bus.mc_wr !== wr_prev || bus.mc_ifetch !== ifetch_prev) begin
        errors++;
        $display("FAIL req_stable: got a=%h w=%0d, required a=%h w=%0d", bus.mc_addr, bus.mc_width, addr_prev, width_prev);
      end
    end
    mk = {bus.if_done, bus.lsb_rdone, bus.lsb_wdone};
    if (mk !== 3'b000 && mk !== 3'bxxx) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got pulses=%b, required none", mk);
      end else begin
        md = done_q.pop_front();
        if (mk !== md.kind) begin
          errors++;
          $display("FAIL done_kind: got pulses=%b, required %b", mk, md.kind);
        end else if (md.kind == 3'b100 && bus.if_block !== md.data) begin
          errors++;
          $display("FAIL if_block: got %h, required %h", bus.if_block, md.data);
        end else if (md.kind == 3'b010 && bus.lsb_rdata !== md.data[31:0]) begin
          errors++;
          $display("FAIL lsb_rdata: got %h, required %h", bus.lsb_rdata, md.data[31:0]);
        end
      end
    end
    en_prev     = bus.mc_en;
    addr_prev   = bus.mc_addr;
    wdata_prev  = bus.mc_wdata;
    width_prev  = bus.mc_width;
    wr_prev     = bus.mc_wr;
    ifetch_prev = bus.mc_ifetch;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic ifetch, input logic wr, input logic [3:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.ifetch = ifetch; r.wr = wr; r.width = width; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic push_done(input logic [2:0] kind, input logic [63:0] data);
    done_t d;
    d.kind = kind; d.data = data;
    done_q.push_back(d);
  endtask

  // Controller model: wait for a request, answer after lat cycles
  task automatic complete(input int lat, input logic [63:0] rd, input logic clr_done);
    int n = 0;
    while (bus.mc_en !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.mc_en !== 1'b1) begin
      errors++;
      $display("FAIL mc_en_timeout: mc_en=%b, required 1", bus.mc_en);
    end
    repeat (lat) tick();
    bus.mc_done  = 1'b1;
    bus.mc_rdata = rd;
    if (clr_done) clr = 1'b1;
    tick();
    bus.mc_done = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; io_full = 1'b0; clr = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_width = 3'd4;
    bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.mc_done = 1'b0; bus.mc_rdata = '0;
    repeat (3) tick();
    checks++;
    if ({bus.mc_en, bus.if_done, bus.lsb_rdone, bus.lsb_wdone} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got en/done=%b, required 0000",
               {bus.mc_en, bus.if_done, bus.lsb_rdone, bus.lsb_wdone});
    end
    checks++;
    if (bus.mc_addr !== 32'h0 || bus.mc_width !== 4'h0 || bus.if_block !== 64'h0 || bus.lsb_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h width=%0d block=%h rdata=%h, required all 0",
               bus.mc_addr, bus.mc_width, bus.if_block, bus.lsb_rdata);
    end
    bus.if_req = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_fetch();
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    push_req(1'b1, 1'b0, 4'd8, 32'h100, 32'h0);
    push_done(3'b100, 64'hA5);
    tick();
    checks++;
    if (bus.mc_en !== 1'b1 || bus.mc_ifetch !== 1'b1 || bus.mc_width !== 4'd8) begin
      errors++;
      $display("FAIL if_grant_latency: got en=%b ifetch=%b width=%0d, required 1 1 8",
               bus.mc_en, bus.mc_ifetch, bus.mc_width);
    end
    complete(9, 64'hA5, 1'b0);
    bus.if_req = 1'b0;
    checks++;
    if (bus.if_done !== 1'b1 || bus.if_block !== 64'hA5 || bus.mc_en !== 1'b0) begin
      errors++;
      $display("FAIL if_done: got done=%b block=%h en=%b, required 1 a5 0", bus.if_done, bus.if_block, bus.mc_en);
    end
    tick();
    checks++;
    if (bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL if_done_pulse: got %b, required 0", bus.if_done);
    end
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.if_addr = 32'h180; bus.if_req = 1'b1;
    bus.lsb_addr = 32'h200; bus.lsb_wr = 1'b0; bus.lsb_width = 3'd4; bus.lsb_req = 1'b1;
    push_req(1'b1, 1'b0, 4'd8, 32'h180, 32'h0);
    push_done(3'b100, 64'h1111_2222_3333_4444);
    push_req(1'b0, 1'b0, 4'd4, 32'h200, 32'h0);
    push_done(3'b010, 64'hFFFF_FFFF_8765_4321);
    push_req(1'b1, 1'b0, 4'd8, 32'h180, 32'h0);
    push_done(3'b100, 64'h5555_6666_7777_8888);
    complete(2, 64'h1111_2222_3333_4444, 1'b0);
    complete(3, 64'hFFFF_FFFF_8765_4321, 1'b0);
    checks++;
    if (bus.lsb_rdone !== 1'b1 || bus.lsb_rdata !== 32'h8765_4321) begin
      errors++;
      $display("FAIL rr_load: got rdone=%b rdata=%h, required 1 87654321", bus.lsb_rdone, bus.lsb_rdata);
    end
    complete(1, 64'h5555_6666_7777_8888, 1'b0);
    bus.if_req = 1'b0; bus.lsb_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.mc_en !== 1'b0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL rr_idle: got en=%b pending=%0d, required 0 0", bus.mc_en, req_q.size());
    end
  endtask

  task automatic test_io_stall();
    logic held;
    io_full = 1'b1;
    bus.lsb_addr = 32'h30004; bus.lsb_wr = 1'b1; bus.lsb_width = 3'd1;
    bus.lsb_wdata = 32'h5A; bus.lsb_req = 1'b1;
    bus.if_addr = 32'h500; bus.if_req = 1'b1;
    push_req(1'b1, 1'b0, 4'd8, 32'h500, 32'h0);
    push_done(3'b100, 64'hABCD);
    complete(2, 64'hABCD, 1'b0);
    bus.if_req = 1'b0;
    held = 1'b1;
    repeat (3) begin
      tick();
      if (bus.mc_en !== 1'b0) held = 1'b0;
    end
    bus.lsb_addr = 32'h30000;
    repeat (3) begin
      tick();
      if (bus.mc_en !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL io_stall_hold: got grant while full, required store held");
    end
    io_full = 1'b0;
    push_req(1'b0, 1'b1, 4'd1, 32'h30000, 32'h5A);
    push_done(3'b001, 64'h0);
    complete(4, 64'h0, 1'b0);
    bus.lsb_req = 1'b0;
    checks++;
    if (bus.lsb_wdone !== 1'b1) begin
      errors++;
      $display("FAIL io_store_done: got wdone=%b, required 1", bus.lsb_wdone);
    end
    tick();
    io_full = 1'b1;
    bus.lsb_addr = 32'h30008; bus.lsb_wdata = 32'hC3; bus.lsb_width = 3'd2; bus.lsb_req = 1'b1;
    push_req(1'b0, 1'b1, 4'd2, 32'h30008, 32'hC3);
    push_done(3'b001, 64'h0);
    complete(1, 64'h0, 1'b0);
    bus.lsb_req = 1'b0; io_full = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    logic [31:0] rd_before;
    logic [63:0] blk_before;
    rd_before = bus.lsb_rdata;
    bus.lsb_addr = 32'h200; bus.lsb_wr = 1'b0; bus.lsb_width = 3'd2; bus.lsb_req = 1'b1;
    push_req(1'b0, 1'b0, 4'd2, 32'h200, 32'h0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.mc_en !== 1'b1) begin
      errors++;
      $display("FAIL clear_hold_en: got %b, required 1", bus.mc_en);
    end
    complete(3, 64'hBEEF, 1'b0);
    bus.lsb_req = 1'b0;
    checks++;
    if (bus.lsb_rdone !== 1'b0 || bus.lsb_rdata !== rd_before) begin
      errors++;
      $display("FAIL clear_load: got rdone=%b rdata=%h, required 0 %h", bus.lsb_rdone, bus.lsb_rdata, rd_before);
    end
    repeat (2) tick();
    blk_before = bus.if_block;
    bus.if_addr = 32'h600; bus.if_req = 1'b1;
    push_req(1'b1, 1'b0, 4'd8, 32'h600, 32'h0);
    complete(2, 64'h77, 1'b1);
    bus.if_req = 1'b0;
    checks++;
    if (bus.if_done !== 1'b0 || bus.if_block !== blk_before) begin
      errors++;
      $display("FAIL clear_with_done: got done=%b block=%h, required 0 %h", bus.if_done, bus.if_block, blk_before);
    end
    repeat (2) tick();
    bus.if_addr = 32'h640; bus.if_req = 1'b1;
    push_req(1'b1, 1'b0, 4'd8, 32'h640, 32'h0);
    push_done(3'b100, 64'h99);
    complete(1, 64'h99, 1'b0);
    bus.if_req = 1'b0;
    repeat (2) tick();
    bus.lsb_addr = 32'h40; bus.lsb_wr = 1'b1; bus.lsb_width = 3'd2;
    bus.lsb_wdata = 32'h1234; bus.lsb_req = 1'b1;
    push_req(1'b0, 1'b1, 4'd2, 32'h40, 32'h1234);
    push_done(3'b001, 64'h0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    complete(2, 64'h0, 1'b1);
    bus.lsb_req = 1'b0;
    checks++;
    if (bus.lsb_wdone !== 1'b1) begin
      errors++;
      $display("FAIL clear_store: got wdone=%b, required 1", bus.lsb_wdone);
    end
    repeat (2) tick();
  endtask

  task automatic test_rdy_freeze();
    logic frozen;
    bus.if_addr = 32'h700; bus.if_req = 1'b1;
    push_req(1'b1, 1'b0, 4'd8, 32'h700, 32'h0);
    tick();
    rdy = 1'b0;
    bus.mc_done = 1'b1; bus.mc_rdata = 64'h1111;
    frozen = 1'b1;
    repeat (3) begin
      tick();
      bus.mc_done = 1'b0;
      if (bus.mc_en !== 1'b1 || bus.if_done !== 1'b0 || bus.mc_addr !== 32'h700) frozen = 1'b0;
    end
    checks++;
    if (frozen !== 1'b1) begin
      errors++;
      $display("FAIL rdy_frozen: got en=%b done=%b addr=%h, required 1 0 700", bus.mc_en, bus.if_done, bus.mc_addr);
    end
    rdy = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.mc_en !== 1'b1 || bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL rdy_done_ignored: got en=%b done=%b, required 1 0", bus.mc_en, bus.if_done);
    end
    push_done(3'b100, 64'h2222);
    complete(0, 64'h2222, 1'b0);
    bus.if_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_busy();
    bus.lsb_addr = 32'h400; bus.lsb_wr = 1'b0; bus.lsb_width = 3'd4; bus.lsb_req = 1'b1;
    push_req(1'b0, 1'b0, 4'd4, 32'h400, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.mc_en, bus.if_done, bus.lsb_rdone, bus.lsb_wdone} !== 4'b0000 || bus.mc_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy: got en/done=%b addr=%h, required 0000 0",
               {bus.mc_en, bus.if_done, bus.lsb_rdone, bus.lsb_wdone}, bus.mc_addr);
    end
    rst = 1'b0;
    push_req(1'b0, 1'b0, 4'd4, 32'h400, 32'h0);
    push_done(3'b010, 64'hCAFE);
    tick();
    checks++;
    if (bus.mc_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_regrant: got en=%b, required 1", bus.mc_en);
    end
    complete(1, 64'hCAFE, 1'b0);
    bus.lsb_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_round_robin();
    test_io_stall();
    test_clear();
    test_rdy_freeze();
    test_reset_busy();
    checks++;
    if (req_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got req=%0d done=%0d pending, required 0 0", req_q.size(), done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
